trng_health_test: RTL

Online entropy health-test stage between the ring-oscillator bit sampler and the key-assembly logic of the TRNG. It checks every raw sampled bit with a repetition count test (RCT) and an adaptive proportion test (APT). Bits are forwarded only after a start-up window has passed with no failure. Any failure latches an alarm that blocks the bit stream until software clears it.

---
 rtl/trng_health_pkg.sv | 16 +
 rtl/trng_health_apt.sv | 48 ++++
 rtl/trng_health_test.sv | 116 +++++++++++
 3 files changed

// File: rtl/trng_health_pkg.sv
// trng_health_pkg: shared state type, default cutoffs and counter-width helper for the TRNG health test.
package trng_health_pkg;

    typedef enum logic [1:0] {IDLE, STARTUP, RUN, ALARM} health_state_e;

    localparam int RCT_CUTOFF_DEF   = 41;
    localparam int APT_WINDOW_DEF   = 1024;
    localparam int APT_CUTOFF_DEF   = 589;
    localparam int STARTUP_BITS_DEF = 1024;
    localparam int FAIL_CNT_W       = 8;

    function automatic int cnt_w(input int v);
        return $clog2(v + 1);
    endfunction

endpackage

// File: rtl/trng_health_apt.sv
// trng_health_apt: adaptive proportion test over fixed windows, combinational fail strobe on the sampling cycle.
module trng_health_apt
    import trng_health_pkg::*;
#(
    parameter int APT_WINDOW = APT_WINDOW_DEF,
    parameter int APT_CUTOFF = APT_CUTOFF_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic sample,
    input  logic sample_bit,
    output logic fail
);

    localparam int WW = cnt_w(APT_WINDOW);
    localparam int MW = cnt_w(APT_CUTOFF);
    localparam logic [WW-1:0] WIN = WW'(APT_WINDOW);
    localparam logic [MW-1:0] CUT = MW'(APT_CUTOFF);

    logic [WW-1:0] win_cnt;
    logic [MW-1:0] match_cnt, match_nxt;
    logic          ref_bit, new_win, hit;

    always_comb begin
        new_win   = win_cnt == '0 || win_cnt == WIN;
        hit       = new_win || sample_bit == ref_bit;
        match_nxt = new_win ? MW'(1) : (hit && match_cnt != CUT) ? match_cnt + MW'(1) : match_cnt;
        fail      = sample && hit && match_nxt == CUT;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt   <= '0;
            match_cnt <= '0;
            ref_bit   <= 1'b0;
        end else if (clear) begin
            win_cnt   <= '0;
            match_cnt <= '0;
            ref_bit   <= 1'b0;
        end else if (sample) begin
            win_cnt   <= new_win ? WW'(1) : win_cnt + WW'(1);
            match_cnt <= match_nxt;
            if (new_win) ref_bit <= sample_bit;
        end
    end

endmodule

// File: rtl/trng_health_test.sv
// trng_health_test: RCT/APT online health test gating the raw TRNG bit stream behind start-up and alarm.
// Define TRNG_HEALTH_APT_EN to include the adaptive proportion test; otherwise apt_fail_o is tied low.
module trng_health_test
    import trng_health_pkg::*;
#(
    parameter int RCT_CUTOFF   = RCT_CUTOFF_DEF,
    parameter int APT_WINDOW   = APT_WINDOW_DEF,
    parameter int APT_CUTOFF   = APT_CUTOFF_DEF,
    parameter int STARTUP_BITS = STARTUP_BITS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  bit_i,
    input  logic                  bit_valid_i,
    input  logic                  alarm_clear_i,
    output logic                  bit_o,
    output logic                  bit_valid_o,
    output logic                  startup_done_o,
    output logic                  rct_fail_o,
    output logic                  apt_fail_o,
    output logic [FAIL_CNT_W-1:0] fail_count_o
);

    localparam int RW = cnt_w(RCT_CUTOFF);
    localparam int SW = cnt_w(STARTUP_BITS);
    localparam logic [RW-1:0] RCT_CUT = RW'(RCT_CUTOFF);
    localparam logic [SW-1:0] SU_LAST = SW'(STARTUP_BITS - 1);

    if (RCT_CUTOFF < 1 || APT_WINDOW < 1 || APT_CUTOFF < 1 || STARTUP_BITS < 1) begin : g_bad_param
        $error("trng_health_test: all cutoffs and window lengths must be positive");
    end

    health_state_e state, state_nxt;
    logic [RW-1:0] run_cnt, run_nxt;
    logic [SW-1:0] su_cnt;
    logic          last_bit, active, sample, clear, rct_hit, apt_hit, fail;

    always_comb begin
        active  = state == STARTUP || state == RUN;
        sample  = active && enable_i && bit_valid_i;
        clear   = (active && !enable_i) || (state == ALARM && alarm_clear_i);
        run_nxt = (run_cnt != '0 && bit_i == last_bit) ? (run_cnt == RCT_CUT ? RCT_CUT : run_cnt + RW'(1)) : RW'(1);
        rct_hit = sample && run_nxt == RCT_CUT;
        fail    = rct_hit || apt_hit;
    end

`ifdef TRNG_HEALTH_APT_EN
    trng_health_apt #(
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF)
    ) u_apt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear     (clear),
        .sample    (sample),
        .sample_bit(bit_i),
        .fail      (apt_hit)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) apt_fail_o <= 1'b0;
        else if (clear) apt_fail_o <= 1'b0;
        else if (apt_hit) apt_fail_o <= 1'b1;
    end
`else
    assign apt_hit    = 1'b0;
    assign apt_fail_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = enable_i ? STARTUP : IDLE;
            STARTUP: state_nxt = !enable_i ? IDLE : fail ? ALARM : (sample && su_cnt == SU_LAST) ? RUN : STARTUP;
            RUN:     state_nxt = !enable_i ? IDLE : fail ? ALARM : RUN;
            default: state_nxt = alarm_clear_i ? (enable_i ? STARTUP : IDLE) : ALARM;
        endcase
    end

    always_comb startup_done_o = state == RUN;

    // A failing sample is dropped here, so forwarding never leaks a bit that tripped a test.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt      <= '0;
            last_bit     <= 1'b0;
            su_cnt       <= '0;
            rct_fail_o   <= 1'b0;
            fail_count_o <= '0;
            bit_o        <= 1'b0;
            bit_valid_o  <= 1'b0;
        end else begin
            bit_valid_o <= sample && state == RUN && !fail;
            if (sample && state == RUN && !fail) bit_o <= bit_i;
            if (fail && fail_count_o != '1) fail_count_o <= fail_count_o + FAIL_CNT_W'(1);
            if (clear) begin
                run_cnt    <= '0;
                last_bit   <= 1'b0;
                su_cnt     <= '0;
                rct_fail_o <= 1'b0;
            end else if (sample) begin
                run_cnt  <= run_nxt;
                last_bit <= bit_i;
                if (state == STARTUP) su_cnt <= su_cnt + SW'(1);
                if (rct_hit) rct_fail_o <= 1'b1;
            end
        end
    end

endmodule
